// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks the digits of a BCD value with
// blank gaps between them, optional leading-zero suppression, and frame-aligned updates.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int GAP_CYCLES  = 2,
  parameter int BLANK_ZEROS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              bcd_out,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int DW   = 4 * NUM_DIGITS;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int PMAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int PW   = $clog2(PMAX);

  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0]         SCAN_END = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]         GAP_END  = PW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [PW-1:0]   presc, presc_n;
  logic [DW-1:0]   active, active_n;
  logic [DW-1:0]   pending, pending_n;
  logic            pending_full, pending_full_n;
  logic            step, boundary;
  logic [3:0]      nib_n;
  logic            nonzero_n, lead_blank_n;

  // Outputs are registered from the next-state values so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_comb begin
    state_n        = state;
    idx_n          = idx;
    presc_n        = presc;
    active_n       = active;
    pending_n      = pending;
    pending_full_n = pending_full;
    step           = 1'b0;
    boundary       = 1'b0;

    case (state)
      IDLE: begin
        if (pending_full) begin
          active_n       = pending;
          pending_full_n = 1'b0;
        end
        if (enable) begin
          state_n = SCAN;
          idx_n   = '0;
          presc_n = '0;
        end
      end
      SCAN, GAP: begin
        if (!enable) begin
          state_n = IDLE;
          idx_n   = '0;
          presc_n = '0;
        end else if (state == SCAN && presc == SCAN_END) begin
          presc_n = '0;
          if (GAP_CYCLES > 0) state_n = GAP;
          else step = 1'b1;
        end else if (state == GAP && presc == GAP_END) begin
          presc_n = '0;
          state_n = SCAN;
          step    = 1'b1;
        end else begin
          presc_n = presc + PW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
        presc_n = '0;
      end
    endcase

    if (step) begin
      if (idx == LAST_IDX) begin
        idx_n    = '0;
        boundary = 1'b1;
      end else begin
        idx_n = idx + IW'(1);
      end
    end

    if (boundary && pending_full) begin
      active_n       = pending;
      pending_full_n = 1'b0;
    end

    if (load_valid && load_ready) begin
      pending_n      = load_data;
      pending_full_n = 1'b1;
    end

    nib_n     = '0;
    nonzero_n = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx_n) nib_n = active_n[4*i +: 4];
      if (IW'(i) >= idx_n && active_n[4*i +: 4] != 4'h0) nonzero_n = 1'b1;
    end
    lead_blank_n = (BLANK_ZEROS != 0) && (idx_n != '0) && !nonzero_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      presc        <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      bcd_out      <= '0;
      blank        <= 1'b1;
      digit_en     <= '1;
      load_ready   <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      presc        <= presc_n;
      active       <= active_n;
      pending      <= pending_n;
      pending_full <= pending_full_n;
      load_ready   <= !pending_full_n;
      frame_done   <= boundary;
      if (state_n == SCAN) begin
        digit_en <= ~(ONE_HOT0 << idx_n);
        bcd_out  <= nib_n;
        blank    <= lead_blank_n;
      end else begin
        digit_en <= '1;
        bcd_out  <= '0;
        blank    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, CLK_DIV=4, GAP_CYCLES=1.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  bcd_out;
  logic        blank;
  logic [3:0]  digit_en;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .CLK_DIV    (4),
    .GAP_CYCLES (1),
    .BLANK_ZEROS(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .bcd_out   (bcd_out),
    .blank     (blank),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // {digit_en, bcd_out, blank, frame_done}; bcd_out is ignored while all digits are off.
  function automatic logic [9:0] obs();
    return {digit_en, (&digit_en) ? 4'h0 : bcd_out, blank, frame_done};
  endfunction

  // Expected vector for cycle c (0..19) of a 20-cycle frame showing val.
  function automatic logic [9:0] exp_vec(input int c, input logic [15:0] val, input bit fd);
    int d;
    int pos;
    logic [15:0] v;
    d   = c / 5;
    pos = c % 5;
    v   = val >> (4 * d);
    if (pos == 4) return {4'hF, 4'h0, 1'b1, 1'b0};
    return {~(4'b0001 << d), v[3:0], (d != 0) && (v == 16'h0), fd && (c == 0)};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({digit_en, bcd_out, blank, frame_done, load_ready} !== {4'hF, 4'h0, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_values got=%b want=%b", {digit_en, bcd_out, blank, frame_done, load_ready},
               {4'hF, 4'h0, 1'b1, 1'b0, 1'b1});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({digit_en, blank, load_ready} !== {4'hF, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=%b", {digit_en, blank, load_ready}, {4'hF, 1'b1, 1'b1});
    end
  endtask

  task automatic test_scan_no_load();
    enable = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      total++;
      if (obs() !== exp_vec((k - 1) % 20, 16'h0000, k > 20)) begin
        bad++;
        $display("FAIL scan_zero k=%0d got=%b want=%b", k, obs(), exp_vec((k - 1) % 20, 16'h0000, k > 20));
      end
    end
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_load_idle();
    load_data  = 16'h1234;
    load_valid = 1'b1;
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready_before got=%b want=1", load_ready);
    end
    @(negedge clk);
    load_valid = 1'b0;
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_ready_low got=%b want=0", load_ready);
    end
    @(negedge clk);
    total++;
    if (load_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready_back got=%b want=1", load_ready);
    end
    enable = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      total++;
      if (obs() !== exp_vec((k - 1) % 20, 16'h1234, k > 20)) begin
        bad++;
        $display("FAIL scan_1234 k=%0d got=%b want=%b", k, obs(), exp_vec((k - 1) % 20, 16'h1234, k > 20));
      end
    end
  endtask

  // Continues from the boundary cycle (k=21) left by test_load_idle.
  task automatic test_load_midframe();
    logic [15:0] val;
    load_data  = 16'h0056;
    load_valid = 1'b1;
    for (int k = 22; k <= 60; k++) begin
      @(negedge clk);
      if (k == 22) load_valid = 1'b0;
      val = (k >= 41) ? 16'h0056 : 16'h1234;
      total++;
      if (obs() !== exp_vec((k - 1) % 20, val, 1'b1)) begin
        bad++;
        $display("FAIL midframe k=%0d got=%b want=%b", k, obs(), exp_vec((k - 1) % 20, val, 1'b1));
      end
      if (k <= 40 || k >= 42) begin
        total++;
        if (load_ready !== (k >= 42)) begin
          bad++;
          $display("FAIL midframe_ready k=%0d got=%b want=%b", k, load_ready, k >= 42);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] val;
    for (int k = 61; k <= 120; k++) begin
      @(negedge clk);
      val = (k < 81) ? 16'h0056 : (k < 101) ? 16'h1111 : 16'h2222;
      total++;
      if (obs() !== exp_vec((k - 1) % 20, val, 1'b1)) begin
        bad++;
        $display("FAIL b2b k=%0d got=%b want=%b", k, obs(), exp_vec((k - 1) % 20, val, 1'b1));
      end
      if (k >= 62 && k != 81 && k != 101) begin
        total++;
        if (load_ready !== (k > 101)) begin
          bad++;
          $display("FAIL b2b_ready k=%0d got=%b want=%b", k, load_ready, k > 101);
        end
      end
      if (k == 61) begin
        load_data  = 16'h1111;
        load_valid = 1'b1;
      end
      if (k == 62) load_data = 16'h2222;
      if (k == 82) load_valid = 1'b0;
    end
  endtask

  task automatic test_disable_gap();
    for (int k = 121; k <= 135; k++) begin
      @(negedge clk);
      total++;
      if (obs() !== exp_vec((k - 1) % 20, 16'h2222, 1'b1)) begin
        bad++;
        $display("FAIL pre_disable k=%0d got=%b want=%b", k, obs(), exp_vec((k - 1) % 20, 16'h2222, 1'b1));
      end
    end
    enable = 1'b0;
    for (int k = 136; k <= 140; k++) begin
      @(negedge clk);
      total++;
      if ({digit_en, blank, frame_done} !== {4'hF, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL disabled k=%0d got=%b want=%b", k, {digit_en, blank, frame_done}, {4'hF, 1'b1, 1'b0});
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      total++;
      if (obs() !== exp_vec((k - 1) % 20, 16'h2222, k > 20)) begin
        bad++;
        $display("FAIL reenable k=%0d got=%b want=%b", k, obs(), exp_vec((k - 1) % 20, 16'h2222, k > 20));
      end
    end
  endtask

  task automatic test_reset_midscan();
    load_data  = 16'h9999;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    total++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_pending_full got=%b want=0", load_ready);
    end
    repeat (5) @(negedge clk);
    total++;
    if ({digit_en, bcd_out, blank} !== {4'b1101, 4'h2, 1'b0}) begin
      bad++;
      $display("FAIL rst_pre_digit1 got=%b want=%b", {digit_en, bcd_out, blank}, {4'b1101, 4'h2, 1'b0});
    end
    #2 rst = 1'b1;
    enable = 1'b0;
    #1;
    total++;
    if ({digit_en, bcd_out, blank, frame_done, load_ready} !== {4'hF, 4'h0, 1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", {digit_en, bcd_out, blank, frame_done, load_ready},
               {4'hF, 4'h0, 1'b1, 1'b0, 1'b1});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      total++;
      if ({obs(), load_ready} !== {exp_vec(k - 1, 16'h0000, 1'b0), 1'b1}) begin
        bad++;
        $display("FAIL post_reset k=%0d got=%b want=%b", k, {obs(), load_ready},
                 {exp_vec(k - 1, 16'h0000, 1'b0), 1'b1});
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_no_load();
    test_load_idle();
    test_load_midframe();
    test_back_to_back();
    test_disable_gap();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
